// File: rtl/regfile_dump.sv
// regfile_dump: walks a register file read port and streams every register out over a valid/ready beat interface.
// Define REGFILE_DUMP_CSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    output logic [REGBITS-1:0] ra_o,
    input  logic [WIDTH-1:0]   rd_i,
    output logic               dump_valid_o,
    input  logic               dump_ready_i,
    output logic [REGBITS-1:0] dump_addr_o,
    output logic [WIDTH-1:0]   dump_data_o,
    output logic               dump_last_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int N = 1 << REGBITS;
    // One spare bit so the final-index comparison never aliases with a wrapped counter.
    localparam logic [REGBITS:0] LAST_IDX = (REGBITS + 1)'(N - 1);

`ifdef REGFILE_DUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [REGBITS:0] cnt;
    logic             kill;

    // Abort outranks everything, including a handshake in the same cycle.
    assign kill = abort_i && (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        if (kill) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) next_state = READ;
                READ: next_state = SEND;
                SEND: begin
                    if (dump_ready_i) begin
                        if (cnt != LAST_IDX) begin
                            next_state = READ;
                        end else begin
`ifdef REGFILE_DUMP_CSUM_EN
                            next_state = CSUM;
`else
                            next_state = DONE;
`endif
                        end
                    end
                end
`ifdef REGFILE_DUMP_CSUM_EN
                CSUM: if (dump_ready_i) next_state = DONE;
`endif
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        ra_o         = '0;
        dump_valid_o = 1'b0;
        busy_o       = (state != IDLE);
        done_o       = (state == DONE);
        if (state == READ) ra_o = cnt[REGBITS-1:0];
`ifdef REGFILE_DUMP_CSUM_EN
        if (state == SEND || state == CSUM) dump_valid_o = 1'b1;
`else
        if (state == SEND) dump_valid_o = 1'b1;
`endif
    end

`ifdef REGFILE_DUMP_CSUM_EN
    logic [WIDTH-1:0] csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (state == IDLE && start_i) begin
            csum <= '0;
        end else if (state == READ && !kill) begin
            csum <= csum ^ rd_i;
        end
    end
`endif

    // Counter and beat registers; the beat only changes on entry to SEND or CSUM, so it is stable while offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            dump_addr_o <= '0;
            dump_data_o <= '0;
            dump_last_o <= 1'b0;
        end else if (!kill) begin
            case (state)
                IDLE: if (start_i) cnt <= '0;
                READ: begin
                    dump_addr_o <= cnt[REGBITS-1:0];
                    dump_data_o <= rd_i;
`ifdef REGFILE_DUMP_CSUM_EN
                    dump_last_o <= 1'b0;
`else
                    dump_last_o <= (cnt == LAST_IDX);
`endif
                end
                SEND: begin
                    if (dump_ready_i) begin
                        if (cnt != LAST_IDX) begin
                            cnt <= cnt + 1'b1;
                        end else begin
`ifdef REGFILE_DUMP_CSUM_EN
                            dump_addr_o <= '0;
                            dump_data_o <= csum;
                            dump_last_o <= 1'b1;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus queues expected beats, a negedge monitor checks handshakes, stalls and done.
`timescale 1ns/1ps
module tb_regfile_dump;

    localparam int WIDTH   = 32;
    localparam int REGBITS = 3;
    localparam int N       = 8;

`ifdef REGFILE_DUMP_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [REGBITS-1:0] addr;
        logic [WIDTH-1:0]   data;
        logic               last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic               abort_i;
    logic [REGBITS-1:0] ra_o;
    logic [WIDTH-1:0]   rd_i;
    logic               dump_valid_o;
    logic               dump_ready_i;
    logic [REGBITS-1:0] dump_addr_o;
    logic [WIDTH-1:0]   dump_data_o;
    logic               dump_last_o;
    logic               busy_o;
    logic               done_o;

    logic [WIDTH-1:0] regs [N] = '{32'h0, 32'h101, 32'h102, 32'h103,
                                   32'h104, 32'h105, 32'h106, 32'h107};
    logic [WIDTH-1:0] exp_data [N] = '{32'h0, 32'h101, 32'h102, 32'h103,
                                       32'h104, 32'h105, 32'h106, 32'h107};
    localparam logic [WIDTH-1:0] EXP_CSUM = 32'h0000_0100;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_hs_cyc = -10;
    bit    last_pending = 1'b0;
    bit    check_gap = 1'b1;

    regfile_dump #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .ra_o         (ra_o),
        .rd_i         (rd_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    assign rd_i = regs[ra_o];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every handshake pops one expected beat; stalls must hold the beat; done must follow the last beat by one cycle.
    initial begin : monitor
        beat_t              exp_b;
        logic [REGBITS-1:0] held_addr;
        logic [WIDTH-1:0]   held_data;
        bit                 stalled;
        int                 prev_hs;
        stalled = 1'b0;
        prev_hs = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled      = 1'b0;
                prev_hs      = -1;
                last_pending = 1'b0;
                continue;
            end
            if (stalled) begin
                check("stall_valid", dump_valid_o, 1);
                check("stall_addr", dump_addr_o, held_addr);
                check("stall_data", dump_data_o, held_data);
            end
            stalled = 1'b0;
            if (!busy_o) prev_hs = -1;
            if (done_o) begin
                check("done_after_last", last_pending, 1);
                if (last_pending) check("done_timing", cyc, last_hs_cyc + 1);
                last_pending = 1'b0;
            end
            if (dump_valid_o && !abort_i) begin
                if (dump_ready_i) begin
                    check("beat_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_b = sb.pop_front();
                        check("beat_addr", dump_addr_o, exp_b.addr);
                        check("beat_data", dump_data_o, exp_b.data);
                        check("beat_last", dump_last_o, exp_b.last);
                    end
                    if (check_gap && prev_hs >= 0) check("beat_gap", cyc - prev_hs, 2);
                    prev_hs = cyc;
                    if (dump_last_o) begin
                        last_pending = 1'b1;
                        last_hs_cyc  = cyc;
                    end
                end else begin
                    stalled   = 1'b1;
                    held_addr = dump_addr_o;
                    held_data = dump_data_o;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int n, input bit with_tail);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = i[REGBITS-1:0];
            b.data = exp_data[i];
            b.last = !CSUM_ON && (i == N - 1);
            sb.push_back(b);
        end
        if (with_tail && CSUM_ON) sb.push_back('{addr: '0, data: EXP_CSUM, last: 1'b1});
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 80 && !seen; k++) begin
            tick();
            if (done_o) seen = 1'b1;
        end
        check(name, seen, 1);
        tick();
        check("idle_after_done", busy_o, 0);
    endtask

    task automatic wait_beat(input logic [REGBITS-1:0] addr, output bit found);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            tick();
            if (dump_valid_o && dump_addr_o == addr) found = 1'b1;
        end
    endtask

    task automatic expect_quiet(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done_o || busy_o) seen = 1'b1;
        end
        check(name, seen, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ra"}, ra_o, 0);
        check({tag, "_valid"}, dump_valid_o, 0);
        check({tag, "_addr"}, dump_addr_o, 0);
        check({tag, "_data"}, dump_data_o, 0);
        check({tag, "_last"}, dump_last_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
    endtask

    initial begin : stimulus
        bit found;
        rst          = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        dump_ready_i = 1'b1;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Plain full dump at full throughput.
        push_beats(N, 1'b1);
        pulse_start();
        wait_done("full_done");
        check("full_drained", sb.size(), 0);

        // A second start while busy must not disturb the sequence.
        push_beats(N, 1'b1);
        pulse_start();
        repeat (3) tick();
        pulse_start();
        wait_done("restart_done");
        check("restart_drained", sb.size(), 0);
        expect_quiet("restart_no_extra");

        // Sink stalls five cycles on beat 3.
        check_gap = 1'b0;
        push_beats(N, 1'b1);
        pulse_start();
        wait_beat(3'd3, found);
        check("stall_found", found, 1);
        dump_ready_i = 1'b0;
        repeat (5) tick();
        check("stall_hold_valid", dump_valid_o, 1);
        check("stall_hold_addr", dump_addr_o, 3);
        dump_ready_i = 1'b1;
        wait_done("stall_done");
        check("stall_drained", sb.size(), 0);
        check_gap = 1'b1;

        // Abort on beat 4 with ready high: beat 4 is discarded, no done.
        push_beats(4, 1'b0);
        pulse_start();
        wait_beat(3'd4, found);
        check("abort_found", found, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_valid", dump_valid_o, 0);
        expect_quiet("abort_quiet");
        check("abort_drained", sb.size(), 0);

        // Asynchronous reset in the middle of reading index 2.
        push_beats(2, 1'b0);
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (busy_o && !dump_valid_o && ra_o == 3'd2) found = 1'b1;
        end
        check("rst_found_read", found, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        tick();
        tick();
        rst = 1'b0;
        expect_quiet("midrst_quiet");
        check("midrst_drained", sb.size(), 0);
        push_beats(N, 1'b1);
        pulse_start();
        wait_done("post_rst_done");
        check("post_rst_drained", sb.size(), 0);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of a register in the register file.
REQ-002 SHALL have parameter REGBITS, default 3, the register address width; the register count is N = 2^REGBITS.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port start_i, input, 1 bit, a dump request sampled only in IDLE.
REQ-006 SHALL have port abort_i, input, 1 bit, which cancels a dump in progress.
REQ-007 SHALL have port ra_o, output, REGBITS bits, the read address driven to the register file read port.
REQ-008 SHALL have port rd_i, input, WIDTH bits, the combinational read data returned for ra_o.
REQ-009 SHALL have port dump_valid_o, output, 1 bit, meaning a beat is offered.
REQ-010 SHALL have port dump_ready_i, input, 1 bit, meaning the sink accepts the beat.
REQ-011 SHALL have port dump_addr_o, output, REGBITS bits, the register index of the beat.
REQ-012 SHALL have port dump_data_o, output, WIDTH bits, the register value of the beat.
REQ-013 SHALL have port dump_last_o, output, 1 bit, which marks the final beat.
REQ-014 SHALL have port busy_o, output, 1 bit, high in every state except IDLE.
REQ-015 SHALL have port done_o, output, 1 bit, a one-cycle pulse on completion.

Function
REQ-016 SHALL implement FSM states IDLE, READ, SEND, CSUM and DONE.
REQ-017 In IDLE with start_i=1, the FSM SHALL clear the address counter to 0 and go to READ.
REQ-018 In READ, the block SHALL drive ra_o from the counter, capture rd_i and the counter into the output registers at the clock edge, and go to SEND.
REQ-019 In SEND, dump_valid_o SHALL be 1, and dump_addr_o and dump_data_o SHALL hold stable until the cycle in which dump_valid_o and dump_ready_i are both 1.
REQ-020 On a SEND handshake with counter below N-1, the block SHALL increment the counter and go to READ; with counter equal to N-1, it SHALL go to CSUM if enabled, otherwise to DONE.
REQ-021 Each register SHALL cost exactly 2 cycles when dump_ready_i is held 1, and each stalled cycle SHALL add one cycle.
REQ-022 Register index 0 SHALL be dumped like any other index; its data is whatever rd_i returns (zero).
REQ-023 dump_last_o SHALL be 1 only on the final beat: index N-1 when CSUM is disabled, the checksum beat when it is enabled.
REQ-024 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-025 start_i outside IDLE SHALL be ignored.
REQ-026 abort_i=1 in any non-IDLE state SHALL force IDLE at the next edge: no done_o, valid drops, and an unaccepted beat is discarded.
REQ-027 abort_i SHALL take priority over a simultaneous handshake.
REQ-028 ra_o SHALL be 0 in every state except READ.
REQ-029 The address counter SHALL be REGBITS+1 bits wide so that the N-1 comparison never wraps.

Reset
REQ-030 Assertion of rst SHALL immediately force: state IDLE, counter 0, ra_o 0, dump_valid_o 0, dump_addr_o 0, dump_data_o 0, dump_last_o 0, busy_o 0, done_o 0, checksum 0.
REQ-031 rst asserted mid-dump SHALL discard all progress, and no done_o SHALL follow the release of reset.

Configuration
REQ-032 Macro REGFILE_DUMP_CSUM_EN defined SHALL accumulate the XOR of every captured rd_i into a WIDTH-bit checksum, cleared on start.
REQ-033 With REGFILE_DUMP_CSUM_EN defined, state CSUM SHALL offer one extra beat with dump_addr_o=0, dump_data_o=checksum and dump_last_o=1, using the same handshake rules, then go to DONE.
REQ-034 With REGFILE_DUMP_CSUM_EN undefined, the CSUM state and the checksum register SHALL not exist, and SEND of index N-1 SHALL go directly to DONE.

Verification
REQ-035 Set regs[i]=0x100+i for i=1..7 (defaults WIDTH=32, REGBITS=3), CSUM off, ready=1, pulse start -> 8 beats with addr 0..7 and data 0x0, 0x101..0x107, last on addr 7, handshakes every 2 cycles, and done_o one cycle after the final handshake.
REQ-036 Same setup with CSUM on -> a 9th beat with addr 0, data 0x00000100 and last=1, then done_o.
REQ-037 Hold ready=0 for 5 cycles on beat addr 3 -> valid stays 1, addr and data stay constant, and the beat completes when ready rises with no lost or duplicated beats.
REQ-038 Assert abort_i during SEND of addr 4 while ready=1 -> no handshake counted, IDLE next cycle, busy_o=0, and no done_o pulse.
REQ-039 Assert rst asynchronously mid-READ -> all outputs 0 in the same cycle; a new start after release dumps from addr 0.
REQ-040 Pulse start_i while busy -> no effect, and the dump sequence is identical to the one in REQ-035.
